// File: rtl/wb_regfile.sv
// MIPS write-back stage and 32 x DATA_W architectural register file.
// Two combinational read ports with same-cycle write-first bypass and a commit counter.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite_in,
    input  logic              MemToReg_in,
    input  logic [DATA_W-1:0] ReadData_in,
    input  logic [DATA_W-1:0] ALU_Result_in,
    input  logic [4:0]        WriteReg_in,
    input  logic [4:0]        ReadReg1,
    input  logic [4:0]        ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WriteData_out,
    output logic [CNT_W-1:0]  WB_Count
);

    logic [DATA_W-1:0] regs [32];
    logic              commit;

    assign WriteData_out = MemToReg_in ? ReadData_in : ALU_Result_in;

    // Gating with reset kills the bypass while reset is held low.
    assign commit = RegWrite_in && (WriteReg_in != 5'd0) && reset;

    function automatic logic [DATA_W-1:0] read_port(
        input logic [4:0]        idx,
        input logic              do_commit,
        input logic [4:0]        wr_idx,
        input logic [DATA_W-1:0] wr_data,
        input logic [DATA_W-1:0] stored
    );
        if (idx == 5'd0)
            return '0;
        else if (do_commit && (idx == wr_idx))
            return wr_data;
        else
            return stored;
    endfunction

    assign ReadData1 = read_port(ReadReg1, commit, WriteReg_in, WriteData_out, regs[ReadReg1]);
    assign ReadData2 = read_port(ReadReg2, commit, WriteReg_in, WriteData_out, regs[ReadReg2]);

    // NOTE: the register array sits under the async reset because every entry must
    // read zero the instant reset asserts; this rules out mapping it onto a RAM macro.
    // NOTE: sequential state uses non-blocking assignments only, so every reader sees
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
            WB_Count <= '0;
        end else if (commit) begin
            regs[WriteReg_in] <= WriteData_out;
            WB_Count          <= WB_Count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them; a CNT_W=4 instance covers counter wrap.
module tb_wb_regfile;

    localparam int DW = 32;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] wd;
        logic [31:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          RegWrite_in;
    logic          MemToReg_in;
    logic [DW-1:0] ReadData_in;
    logic [DW-1:0] ALU_Result_in;
    logic [4:0]    WriteReg_in;
    logic [4:0]    ReadReg1;
    logic [4:0]    ReadReg2;
    logic [DW-1:0] ReadData1, ReadData2, WriteData_out;
    logic [31:0]   WB_Count;
    logic [DW-1:0] w_ReadData1, w_ReadData2, w_WriteData_out;
    logic [3:0]    w_WB_Count;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .reset(reset), .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
        .ReadData_in(ReadData_in), .ALU_Result_in(ALU_Result_in), .WriteReg_in(WriteReg_in),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1),
        .ReadData2(ReadData2), .WriteData_out(WriteData_out), .WB_Count(WB_Count)
    );

    wb_regfile #(.DATA_W(32), .CNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
        .ReadData_in(ReadData_in), .ALU_Result_in(ALU_Result_in), .WriteReg_in(WriteReg_in),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(w_ReadData1),
        .ReadData2(w_ReadData2), .WriteData_out(w_WriteData_out), .WB_Count(w_WB_Count)
    );

    task automatic check(input string name, input string field,
                         input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, actual, expected);
    endtask

    // Drives one cycle of inputs just after the rising edge and queues what the
    // outputs must show before the next rising edge.
    task automatic step(input string name, input logic rst, input logic rw, input logic m2r,
                        input logic [31:0] rdata, input logic [31:0] alu, input logic [4:0] wr,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                        input logic [31:0] e_wd, input logic [31:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        RegWrite_in   = rw;
        MemToReg_in   = m2r;
        ReadData_in   = rdata;
        ALU_Result_in = alu;
        WriteReg_in   = wr;
        ReadReg1      = r1;
        ReadReg2      = r2;
        e.name = name;
        e.rd1  = e_rd1;
        e.rd2  = e_rd2;
        e.wd   = e_wd;
        e.cnt  = e_cnt;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [31:0] cnt4;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cnt4 = {28'd0, e.cnt[3:0]};
                check(e.name, "ReadData1", ReadData1, e.rd1);
                check(e.name, "ReadData2", ReadData2, e.rd2);
                check(e.name, "WriteData_out", WriteData_out, e.wd);
                check(e.name, "WB_Count", WB_Count, e.cnt);
                check(e.name, "WB_Count_w4", {28'd0, w_WB_Count}, cnt4);
            end
        end
    end

    initial begin : driver
        int waited;
        reset = 1'b0; RegWrite_in = 1'b0; MemToReg_in = 1'b0; ReadData_in = '0;
        ALU_Result_in = '0; WriteReg_in = '0; ReadReg1 = '0; ReadReg2 = '0;

        //   name          rst rw m2r rdata          alu            wr  r1  r2  rd1            rd2            wd             cnt
        step("in_reset",     0, 1, 0, 32'h0,         32'h77,        5,  5,  0,  32'h0,         32'h0,         32'h77,        0);
        step("wr5",          1, 1, 0, 32'h0,         32'h1234,      5,  5,  0,  32'h1234,      32'h0,         32'h1234,      0);
        step("rd5",          1, 0, 1, 32'hDEADBEEF,  32'h0,         9,  5,  9,  32'h1234,      32'h0,         32'hDEADBEEF,  1);
        step("wr9",          1, 1, 1, 32'hDEADBEEF,  32'h0,         9,  0,  5,  32'h0,         32'h1234,      32'hDEADBEEF,  1);
        step("rd9",          1, 0, 0, 32'h0,         32'h0,         0,  9,  9,  32'hDEADBEEF,  32'hDEADBEEF,  32'h0,         2);
        step("wr7_1",        1, 1, 0, 32'h0,         32'h1,         7,  7,  5,  32'h1,         32'h1234,      32'h1,         2);
        step("bypass7",      1, 1, 0, 32'h0,         32'h2,         7,  7,  7,  32'h2,         32'h2,         32'h2,         3);
        step("reg0_write",   1, 1, 0, 32'h0,         32'hFFFFFFFF,  0,  0,  0,  32'h0,         32'h0,         32'hFFFFFFFF,  4);
        step("reg0_after",   1, 0, 0, 32'h0,         32'h0,         0,  7,  0,  32'h2,         32'h0,         32'h0,         4);
        step("bubble",       1, 0, 0, 32'h0,         32'hAAAAAAAA,  3,  3,  7,  32'h0,         32'h2,         32'hAAAAAAAA,  4);
        step("bubble_after", 1, 0, 0, 32'h0,         32'h5,         0,  3,  9,  32'h0,         32'hDEADBEEF,  32'h5,         4);
        step("b2b_a",        1, 1, 0, 32'h0,         32'h11,        12, 12, 0,  32'h11,        32'h0,         32'h11,        4);
        step("b2b_b",        1, 1, 0, 32'h0,         32'h22,        12, 12, 12, 32'h22,        32'h22,        32'h22,        5);
        step("b2b_after",    1, 0, 0, 32'h0,         32'h0,         0,  12, 0,  32'h22,        32'h0,         32'h0,         6);

        // Ten more commits (7th..16th): the 4-bit counter reads 15 before the 16th edge, then 0.
        for (int i = 0; i < 10; i++)
            step("wrap_fill", 1, 1, 0, 32'h0, 32'(100 + i), 5'(20 + i), 5'(20 + i), 5,
                 32'(100 + i), 32'h1234, 32'(100 + i), 32'(6 + i));
        step("wrap_check",   1, 0, 0, 32'h0,         32'h0,         0,  20, 29, 32'd100,       32'd109,       32'h0,         16);

        // Reset asserted 1 ns after an edge: outputs must clear well before the next edge.
        step("async_rst",    0, 1, 0, 32'h0,         32'h33,        20, 20, 5,  32'h0,         32'h0,         32'h33,        0);
        for (int i = 1; i < 32; i++)
            step("rst_sweep", 0, 0, 0, 32'h0, 32'h0, 0, 5'(i), 5'(32 - i), 32'h0, 32'h0, 32'h0, 0);
        step("post_rst",     1, 1, 0, 32'h0,         32'h44,        4,  4,  5,  32'h44,        32'h0,         32'h44,        0);
        step("post_rst2",    1, 0, 0, 32'h0,         32'h0,         0,  4,  20, 32'h44,        32'h0,         32'h0,         1);

        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the five-stage MIPS pipeline. It consumes the control and data fields held in the MEM/WB pipeline register and selects the write-back value (load data or ALU result). It commits that value into a 32 x 32-bit register file and serves the two combinational read ports used by the ID stage. A same-cycle write-to-read bypass lets an instruction in ID see the value being written back in that cycle, and a commit counter supports debug and verification.

## Interface

Parameters:
- `DATA_W`, default 32: register and data width.
- `CNT_W`, default 32: width of the write-back commit counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately when low.
- `RegWrite_in`  in  1  write-back enable, from MEM/WB.
- `MemToReg_in`  in  1  1 selects `ReadData_in`, 0 selects `ALU_Result_in`.
- `ReadData_in`  in  DATA_W  data memory load value, from MEM/WB.
- `ALU_Result_in`  in  DATA_W  ALU result, from MEM/WB.
- `WriteReg_in`  in  5  destination register index, from MEM/WB.
- `ReadReg1`  in  5  ID-stage source index rs.
- `ReadReg2`  in  5  ID-stage source index rt.
- `ReadData1`  out  DATA_W  value of `ReadReg1`, combinational.
- `ReadData2`  out  DATA_W  value of `ReadReg2`, combinational.
- `WriteData_out`  out  DATA_W  selected write-back value, combinational; feeds the forwarding muxes in EX.
- `WB_Count`  out  CNT_W  number of committed register writes since reset, registered.

## Operation

- Write-back select: `WriteData_out = MemToReg_in ? ReadData_in : ALU_Result_in`. It is computed combinationally, independent of `RegWrite_in`.
- Commit condition: `commit = RegWrite_in && (WriteReg_in != 0) && reset`.
- On a rising edge with `commit` true:
  - `regs[WriteReg_in] <= WriteData_out`
  - `WB_Count <= WB_Count + 1`, which wraps modulo 2^CNT_W.
- Register 0 is hardwired to zero:
  - writes to index 0 are discarded and do not increment `WB_Count`;
  - reads of index 0 return 0.
- Read port n (n = 1, 2):
  - if `ReadRegn == 0`, return 0;
  - else if `commit` is true and `ReadRegn == WriteReg_in`, return `WriteData_out` (write-first bypass);
  - else return `regs[ReadRegn]`.
- Both read ports are independent. Both may address the same register, and both may bypass in the same cycle.
- There is no stall or handshake. The block accepts one write-back per cycle, every cycle; a bubble is signalled by `RegWrite_in = 0`.
- Reset (`reset` low, asynchronous):
  - all 32 registers and `WB_Count` clear to 0 without waiting for a clock edge;
  - `commit` is forced false, so the bypass is disabled and `ReadData1` and `ReadData2` read 0;
  - `WriteData_out` keeps following its inputs.
- Reset released mid-stream: the first rising edge with `reset` high commits normally. No inputs captured during reset are replayed.

## Timing

- Write latency: the value is visible in `regs` after the rising edge of the commit cycle. Through the bypass it is visible on the read ports within the commit cycle itself, so effectively zero cycles.
- Read latency: zero cycles (combinational from `ReadRegn`, `regs` and the write-back inputs).
- `WB_Count` updates on the same edge as the register write.
- Back-to-back writes to the same register on consecutive cycles: each edge overwrites, and reads always reflect the most recent committed or committing value.
- Simultaneous `RegWrite_in = 1`, `WriteReg_in = 0` and `ReadReg1 = 0`: `ReadData1 = 0`, no write, and the counter is unchanged.
- Counter wrap: at `WB_Count = 2^CNT_W - 1`, the next commit yields 0 with no flag.
- Reset values of the outputs:
  - `ReadData1 = 0`, `ReadData2 = 0`, `WB_Count = 0`;
  - `WriteData_out` follows its inputs.

## Test plan

- Reset: drive `reset` = 0 asynchronously mid-cycle after several writes. Required: `ReadData1`/`ReadData2` = 0 for every index and `WB_Count` = 0 immediately, before the next edge.
- Basic write/read: commit `RegWrite_in=1`, `MemToReg_in=0`, `ALU_Result_in=32'h0000_1234`, `WriteReg_in=5`. Required: on the next cycle `ReadReg1=5` gives `32'h0000_1234` and `WB_Count=1`. Repeat with `MemToReg_in=1`, `ReadData_in=32'hDEAD_BEEF` to reg 9 and require `32'hDEAD_BEEF`.
- Same-cycle bypass: reg 7 holds `32'h1`. In one cycle, write `32'h2` to reg 7 with `ReadReg1=ReadReg2=7`. Required: both ports show `32'h2` in that cycle, and reg 7 holds `32'h2` afterwards.
- Register 0: write `32'hFFFF_FFFF` to index 0 with `ReadReg2=0`. Required: `ReadData2=0` in that cycle and the next, and `WB_Count` unchanged.
- Bubble: `RegWrite_in=0`, `WriteReg_in=3`, `ALU_Result_in=32'hAAAA_AAAA`. Required: reg 3 unchanged, no bypass on `ReadReg1=3`, `WriteData_out=32'hAAAA_AAAA`.
- Counter wrap: with `CNT_W=4`, perform 16 commits to nonzero registers. Required: `WB_Count` = 15 after commit 15 and 0 after commit 16.
